// File: rtl/mtimer_pkg.sv
// mtimer_pkg -- shared constants and types for the mtimer peripheral.
//
// Contents:
//   DATA_WIDTH, MEM_ADDR_WIDTH : system bus geometry (bus word offset width)
//   tmr_reg_e                  : register slot within a channel's 4-word window
//   TMR_CLR/START/STOP         : CMD bit positions
//   CFG_*                      : CFG bit positions
//   chan_wr_t                  : per-channel register write strobes
//   decode_wr()                : turns a channel write into one strobe
package mtimer_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 8;
  localparam int MAX_CHANNELS   = 8;

  // Register slot inside a channel window; channel n occupies 4n..4n+3.
  typedef enum logic [1:0] {
    TMR_COUNT = 2'd0,
    TMR_CMD   = 2'd1,
    TMR_CMP   = 2'd2,
    TMR_CFG   = 2'd3
  } tmr_reg_e;

  // CMD bits; may be combined in one write.
  localparam int TMR_CLR   = 0;
  localparam int TMR_START = 1;
  localparam int TMR_STOP  = 2;

  // CFG bits. MATCH and OVF are sticky status, write-1-to-clear.
  localparam int CFG_PERIODIC = 0;
  localparam int CFG_IRQ_EN   = 1;
  localparam int CFG_MATCH    = 8;
  localparam int CFG_OVF      = 9;

  typedef struct packed {
    logic count;
    logic cmd;
    logic cmp;
    logic cfg;
  } chan_wr_t;

  function automatic chan_wr_t decode_wr(input logic we, input tmr_reg_e sel);
    chan_wr_t s;
    s = '0;
    if (we) begin
      unique case (sel)
        TMR_COUNT: s.count = 1'b1;
        TMR_CMD:   s.cmd   = 1'b1;
        TMR_CMP:   s.cmp   = 1'b1;
        TMR_CFG:   s.cfg   = 1'b1;
        default:   s       = '0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/mtimer_if.sv
// mtimer_if -- system bus slave port of the mtimer peripheral.
//
// Signals:
//   addr  : local word offset (from address decoder)
//   idata : write data
//   odata : read data, combinational from addr
//   cs_   : chip select, 0 = selected
//   rw_   : 0 = write, 1 = read
//   irq   : per-channel level interrupt, active-high
// Modports: master (CPU / bus side), slave (timer side).
interface mtimer_if #(
  parameter int CHANNELS = 4
);

  logic [mtimer_pkg::MEM_ADDR_WIDTH-1:0] addr;
  logic [mtimer_pkg::DATA_WIDTH-1:0]     idata;
  logic [mtimer_pkg::DATA_WIDTH-1:0]     odata;
  logic                                  cs_;
  logic                                  rw_;
  logic [CHANNELS-1:0]                   irq;

  modport master (
    output addr, idata, cs_, rw_,
    input  odata, irq
  );

  modport slave (
    input  addr, idata, cs_, rw_,
    output odata, irq
  );

endinterface

// File: rtl/mtimer_channel.sv
// mtimer_channel -- one timer channel: counter, compare, enable, CFG, flags.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   wr       : register write strobes for this channel (already decoded)
//   wdata    : bus write data
//   tick     : shared prescaler tick; the counter only steps on a tick
//   count    : current count
//   cmp      : compare value
//   en       : running (read back as CMD bit1)
//   cfg_rd   : CFG read value {ovf@9, match@8, irq_en@1, periodic@0}
//   irq      : irq_en & match
module mtimer_channel
  import mtimer_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  chan_wr_t              wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  tick,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  cmp,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] cfg_rd,
  output logic                  irq
);

  logic periodic;
  logic irq_en;
  logic match;
  logic ovf;

  logic cmd_clr;
  logic cmd_start;
  logic cmd_stop;
  logic step;
  logic hit;
  logic wrap;

  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 en_nxt;
  logic                 match_nxt;
  logic                 ovf_nxt;

  assign cmd_clr   = wr.cmd & wdata[TMR_CLR];
  assign cmd_start = wr.cmd & wdata[TMR_START];
  assign cmd_stop  = wr.cmd & wdata[TMR_STOP];

  // A match takes precedence over the all-ones wrap, so a compare value
  // of all-ones matches instead of overflowing.
  assign step = en & tick;
  assign hit  = step & (count == cmp);
  assign wrap = step & (count != cmp) & (&count);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if-chain leaves it unassigned (which would infer a latch).
  always_comb begin
    count_nxt = count;
    if (cmd_clr) begin
      count_nxt = '0;
    end else if (wr.count) begin
      count_nxt = wdata[CNT_WIDTH-1:0];
    end else if (hit) begin
      // One-shot holds at the compare value.
      count_nxt = periodic ? '0 : count;
    end else if (wrap) begin
      count_nxt = '0;
    end else if (step) begin
      count_nxt = count + CNT_WIDTH'(1);
    end

    en_nxt = en;
    if (cmd_stop) begin
      en_nxt = 1'b0;
    end else if (cmd_start) begin
      en_nxt = 1'b1;
    end else if (hit && !periodic) begin
      en_nxt = 1'b0;
    end

    // Hardware set beats a coincident write-1-to-clear.
    match_nxt = hit  | (match & ~(wr.cfg & wdata[CFG_MATCH]));
    ovf_nxt   = wrap | (ovf   & ~(wr.cfg & wdata[CFG_OVF]));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: all registers are reset (this block holds no memory arrays), since
  // the bus must read back defined values right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      cmp      <= '1;
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      match    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      count <= count_nxt;
      en    <= en_nxt;
      match <= match_nxt;
      ovf   <= ovf_nxt;
      if (wr.cmp) begin
        cmp <= wdata[CNT_WIDTH-1:0];
      end
      if (wr.cfg) begin
        periodic <= wdata[CFG_PERIODIC];
        irq_en   <= wdata[CFG_IRQ_EN];
      end
    end
  end

  always_comb begin
    cfg_rd               = '0;
    cfg_rd[CFG_PERIODIC] = periodic;
    cfg_rd[CFG_IRQ_EN]   = irq_en;
    cfg_rd[CFG_MATCH]    = match;
    cfg_rd[CFG_OVF]      = ovf;
  end

  // Overflow is status only; it never raises the interrupt.
  assign irq = irq_en & match;

endmodule

// File: rtl/mtimer.sv
// mtimer -- multi-channel memory-mapped timer, system bus slave.
//
// Parameters:
//   CHANNELS  : number of channels, 1..8
//   CNT_WIDTH : counter/compare width, <= DATA_WIDTH (zero-extended on read)
//   PRE_WIDTH : prescaler width
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : mtimer_if slave port (addr, idata, odata, cs_, rw_, irq)
// Address map (word offsets): channel n at 4n + {COUNT, CMD, CMP, CFG},
// PRESCALE at 4*CHANNELS, everything else reads 0 and ignores writes.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  mtimer_if.slave  bus
);

  localparam logic [MEM_ADDR_WIDTH-1:0] PRE_ADDR = MEM_ADDR_WIDTH'(4 * CHANNELS);

  logic                 we;
  tmr_reg_e             reg_sel;
  logic                 pre_wr;
  logic                 tick;
  logic [PRE_WIDTH-1:0] prescale;
  logic [PRE_WIDTH-1:0] pcnt;

  logic [CNT_WIDTH-1:0]  ch_count [CHANNELS];
  logic [CNT_WIDTH-1:0]  ch_cmp   [CHANNELS];
  logic [DATA_WIDTH-1:0] ch_cfg   [CHANNELS];
  logic [CHANNELS-1:0]   ch_en;
  logic [CHANNELS-1:0]   irq_vec;
  logic [DATA_WIDTH-1:0] rdata;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign we      = ~bus.cs_ & ~bus.rw_;
  assign reg_sel = tmr_reg_e'(bus.addr[1:0]);
  assign pre_wr  = we & (bus.addr == PRE_ADDR);

  // ---------------------------------------------------------------------------
  // Shared prescaler: tick when pcnt reaches PRESCALE. Writing PRESCALE
  // restarts the phase so the first tick after a rewrite is a full period away.
  // ---------------------------------------------------------------------------
  assign tick = (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (pre_wr) begin
        prescale <= bus.idata[PRE_WIDTH-1:0];
      end
      if (pre_wr || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRE_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic     ch_sel;
    chan_wr_t ch_wr;

    assign ch_sel = (bus.addr[MEM_ADDR_WIDTH-1:2] == (MEM_ADDR_WIDTH-2)'(n));
    assign ch_wr  = decode_wr(we & ch_sel, reg_sel);

    mtimer_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr     (ch_wr),
      .wdata  (bus.idata),
      .tick   (tick),
      .count  (ch_count[n]),
      .cmp    (ch_cmp[n]),
      .en     (ch_en[n]),
      .cfg_rd (ch_cfg[n]),
      .irq    (irq_vec[n])
    );
  end

  // ---------------------------------------------------------------------------
  // Read mux: purely combinational, no read side effects.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.addr[MEM_ADDR_WIDTH-1:2] == (MEM_ADDR_WIDTH-2)'(i)) begin
        unique case (reg_sel)
          TMR_COUNT: rdata            = DATA_WIDTH'(ch_count[i]);
          TMR_CMD:   rdata[TMR_START] = ch_en[i];
          TMR_CMP:   rdata            = DATA_WIDTH'(ch_cmp[i]);
          TMR_CFG:   rdata            = ch_cfg[i];
          default:   rdata            = '0;
        endcase
      end
    end
    if (bus.addr == PRE_ADDR) begin
      rdata = DATA_WIDTH'(prescale);
    end
  end

  assign bus.odata = rdata;
  assign bus.irq   = irq_vec;

endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer -- directed, table-driven bench for mtimer (CHANNELS=4).
// Offsets: ch n COUNT=4n, CMD=4n+1, CMP=4n+2, CFG=4n+3, PRESCALE=16.
module tb_mtimer;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mtimer_if #(.CHANNELS(CH)) bus ();

  mtimer #(
    .CHANNELS  (CH),
    .CNT_WIDTH (32),
    .PRE_WIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_IDLE, OP_RST} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;   // write data, expected read data, or idle cycles
    logic [3:0]  irq;    // expected irq on reads
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input op_e op, input logic [7:0] a,
                              input logic [31:0] d, input logic [3:0] i,
                              input string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.irq = i; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs change #1 after a posedge; a write lands on the next posedge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.addr = a; bus.idata = d; bus.cs_ = 1'b0; bus.rw_ = 1'b0;
    @(posedge clk); #1;
    bus.cs_ = 1'b1; bus.rw_ = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.addr = a; bus.cs_ = 1'b0; bus.rw_ = 1'b1;
    #1;
    check(name, bus.odata, exp);
  endtask

  task automatic chk_irq(input string name, input logic [3:0] exp);
    check(name, 32'(bus.irq), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.addr = '0; bus.idata = '0; bus.cs_ = 1'b1; bus.rw_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- Reset values, unmapped offsets, ch0 periodic with W1C -------------
    vecs.push_back(mk(OP_RST,  0, 0, 0, "rst"));
    vecs.push_back(mk(OP_RD,   0, 32'h0,        4'h0, "rst_count0"));
    vecs.push_back(mk(OP_RD,   1, 32'h0,        4'h0, "rst_cmd0"));
    vecs.push_back(mk(OP_RD,   2, 32'hFFFFFFFF, 4'h0, "rst_cmp0"));
    vecs.push_back(mk(OP_RD,   3, 32'h0,        4'h0, "rst_cfg0"));
    vecs.push_back(mk(OP_RD,   6, 32'hFFFFFFFF, 4'h0, "rst_cmp1"));
    vecs.push_back(mk(OP_RD,  12, 32'h0,        4'h0, "rst_count3"));
    vecs.push_back(mk(OP_RD,  14, 32'hFFFFFFFF, 4'h0, "rst_cmp3"));
    vecs.push_back(mk(OP_RD,  15, 32'h0,        4'h0, "rst_cfg3"));
    vecs.push_back(mk(OP_RD,  16, 32'h0,        4'h0, "rst_prescale"));
    vecs.push_back(mk(OP_RD,  17, 32'h0,        4'h0, "rst_unmapped17"));
    vecs.push_back(mk(OP_RD, 255, 32'h0,        4'h0, "rst_unmapped255"));
    vecs.push_back(mk(OP_WR,  17, 32'hDEADBEEF, 4'h0, ""));
    vecs.push_back(mk(OP_RD,  17, 32'h0,        4'h0, "unmapped_wr_ignored"));
    vecs.push_back(mk(OP_WR,   2, 32'd3,        4'h0, ""));
    vecs.push_back(mk(OP_WR,   3, 32'h3,        4'h0, ""));
    vecs.push_back(mk(OP_WR,   1, 32'h2,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd0,        4'h0, "p_after_start"));
    vecs.push_back(mk(OP_RD,   1, 32'h2,        4'h0, "p_cmd_en"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd1,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd1,        4'h0, "p_c1"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd1,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd2,        4'h0, "p_c2"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd1,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd3,        4'h0, "p_c3"));
    vecs.push_back(mk(OP_RD,   3, 32'h3,        4'h0, "p_cfg_nomatch"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd1,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd0,        4'h1, "p_wrap"));
    vecs.push_back(mk(OP_RD,   3, 32'h103,      4'h1, "p_match"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd1,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd1,        4'h1, "p_c1_again"));
    vecs.push_back(mk(OP_WR,   3, 32'h103,      4'h0, ""));
    vecs.push_back(mk(OP_RD,   3, 32'h3,        4'h0, "p_w1c"));
    vecs.push_back(mk(OP_RD,   0, 32'd2,        4'h0, "p_c2_after_w1c"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd2,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   3, 32'h103,      4'h1, "p_rematch"));
    vecs.push_back(mk(OP_WR,   3, 32'h103,      4'h0, ""));
    vecs.push_back(mk(OP_RD,   3, 32'h3,        4'h0, "p_w1c2"));
    vecs.push_back(mk(OP_IDLE, 0, 32'd2,        4'h0, ""));
    vecs.push_back(mk(OP_RD,   0, 32'd3,        4'h0, "p_c3_before_clash"));
    vecs.push_back(mk(OP_WR,   3, 32'h103,      4'h0, ""));
    vecs.push_back(mk(OP_RD,   3, 32'h103,      4'h1, "set_beats_w1c"));
    vecs.push_back(mk(OP_RD,   0, 32'd0,        4'h1, "set_beats_w1c_count"));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   wr(vecs[i].addr, vecs[i].data);
        OP_RD: begin
          chk_rd(vecs[i].name, vecs[i].addr, vecs[i].data);
          chk_irq({vecs[i].name, "_irq"}, vecs[i].irq);
        end
        OP_IDLE: idle(int'(vecs[i].data));
        default: do_reset();
      endcase
    end

    // ---- Ch1 one-shot while ch0 runs periodic without irq_en ---------------
    do_reset();
    wr(2, 3); wr(3, 32'h1); wr(6, 5); wr(7, 32'h2);
    wr(1, 32'h2);  // ch0 start
    wr(5, 32'h2);  // ch1 start, one cycle later
    idle(6);
    chk_rd("os_count1", 4, 5);
    chk_rd("os_cmd1", 5, 0);
    chk_rd("os_cfg1", 7, 32'h102);
    chk_irq("os_irq", 4'b0010);
    chk_rd("os_count0", 0, 3);
    chk_rd("os_cfg0", 3, 32'h101);
    chk_rd("os_cmd0", 1, 32'h2);
    idle(1);
    chk_rd("os_hold1", 4, 5);
    chk_rd("os_run0", 0, 0);

    // ---- Prescaler: one step per 3 cycles, rewrite restarts phase ---------
    do_reset();
    wr(16, 2);
    wr(9, 32'h2);
    chk_rd("ps_start", 8, 0);
    idle(2);  chk_rd("ps_first", 8, 1);
    idle(2);  chk_rd("ps_hold", 8, 1);
    idle(1);  chk_rd("ps_second", 8, 2);
    idle(1);
    wr(16, 2);
    chk_rd("ps_rewrite", 16, 2);
    idle(1);  chk_rd("ps_phase_restart", 8, 2);
    idle(1);  chk_rd("ps_phase_restart2", 8, 2);
    idle(1);  chk_rd("ps_after_restart", 8, 3);

    // ---- Ch3 match near top of range, then overflow without irq -----------
    do_reset();
    wr(12, 32'hFFFFFFFE); wr(14, 32'hFFFFFFFE); wr(15, 32'h2);
    wr(13, 32'h2);
    idle(1);
    chk_rd("hi_match_count", 12, 32'hFFFFFFFE);
    chk_rd("hi_match_cfg", 15, 32'h102);
    chk_irq("hi_match_irq", 4'b1000);
    chk_rd("hi_match_cmd", 13, 0);
    wr(15, 32'h102);
    chk_irq("hi_w1c_irq", 4'b0000);
    wr(14, 0); wr(12, 32'hFFFFFFFF); wr(13, 32'h2);
    idle(1);
    chk_rd("ovf_wrap_count", 12, 0);
    chk_rd("ovf_flag", 15, 32'h202);
    chk_irq("ovf_no_irq", 4'b0000);
    wr(13, 32'h4);
    chk_rd("ovf_then_match", 15, 32'h302);
    chk_irq("ovf_then_match_irq", 4'b1000);
    wr(15, 32'h302);
    chk_rd("ovf_w1c", 15, 32'h002);

    // ---- Same-cycle priorities on count/en --------------------------------
    do_reset();
    wr(2, 100); wr(1, 32'h2);
    idle(3);  chk_rd("pri_run", 0, 3);
    wr(0, 50);
    chk_rd("count_wr_over_step", 0, 50);
    idle(1);  chk_rd("count_after_wr", 0, 51);
    wr(1, 32'h7);
    chk_rd("cmd7_count", 0, 0);
    chk_rd("cmd7_en", 1, 0);
    idle(2);  chk_rd("cmd7_stopped", 0, 0);
    wr(1, 32'h3);
    chk_rd("clr_start_en", 1, 32'h2);
    idle(1);  chk_rd("clr_start_count", 0, 1);

    // ---- Reset mid-count and reset during a write --------------------------
    do_reset();
    wr(2, 1); wr(3, 32'h3); wr(16, 1); wr(1, 32'h2);
    idle(4);
    chk_irq("pre_rst_irq", 4'b0001);
    chk_rd("pre_rst_prescale", 16, 1);
    do_reset();
    chk_irq("mid_rst_irq", 4'b0000);
    chk_rd("mid_rst_count0", 0, 0);
    chk_rd("mid_rst_cmd0", 1, 0);
    chk_rd("mid_rst_cmp0", 2, 32'hFFFFFFFF);
    chk_rd("mid_rst_cfg0", 3, 0);
    chk_rd("mid_rst_prescale", 16, 0);
    bus.addr = 8'd2; bus.idata = 32'd7; bus.cs_ = 1'b0; bus.rw_ = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.cs_ = 1'b1; bus.rw_ = 1'b1;
    chk_rd("rst_beats_write", 2, 32'hFFFFFFFF);
    idle(2);
    chk_rd("post_rst_idle_count", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
